// File: rtl/ysyx_22041071_lsu_axi_pkg.sv
// Shared AXI constants and LSU state encoding for the data-side AXI master.
package ysyx_22041071_lsu_axi_pkg;

    localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_A  = 3'd1,
        RD_D  = 3'd2,
        WR_AW = 3'd3,
        WR_B  = 3'd4,
        RESP  = 3'd5
    } lsu_state_t;

endpackage

// File: rtl/ysyx_22041071_lsu_axi.sv
// Data-side AXI4 master: turns one MEM-stage load or store into a single-beat
// AXI4 transaction, one outstanding at a time.
module ysyx_22041071_lsu_axi
    import ysyx_22041071_lsu_axi_pkg::*;
#(
    parameter int unsigned       ADDR_W = 32,
    parameter int unsigned       DATA_W = 64,
    parameter int unsigned       ID_W   = 4,
    parameter logic [ID_W-1:0]   AXI_ID = 4'h1
) (
    input  logic                  clk,
    input  logic                  reset,
    // MEM-stage request / response
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_wen,
    input  logic [63:0]           req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    // AW
    output logic                  aw_valid,
    input  logic                  aw_ready,
    output logic [ID_W-1:0]       aw_id,
    output logic [ADDR_W-1:0]     aw_addr,
    output logic [7:0]            aw_len,
    output logic [2:0]            aw_size,
    output logic [1:0]            aw_burst,
    // W
    output logic                  w_valid,
    input  logic                  w_ready,
    output logic [DATA_W-1:0]     w_data,
    output logic [DATA_W/8-1:0]   w_strb,
    output logic                  w_last,
    // B
    input  logic                  b_valid,
    output logic                  b_ready,
    input  logic [ID_W-1:0]       b_id,
    input  logic [1:0]            b_resp,
    // AR
    output logic                  ar_valid,
    input  logic                  ar_ready,
    output logic [ID_W-1:0]       ar_id,
    output logic [ADDR_W-1:0]     ar_addr,
    output logic [7:0]            ar_len,
    output logic [2:0]            ar_size,
    output logic [1:0]            ar_burst,
    // R
    input  logic                  r_valid,
    output logic                  r_ready,
    input  logic [ID_W-1:0]       r_id,
    input  logic [DATA_W-1:0]     r_data,
    input  logic [1:0]            r_resp,
    input  logic                  r_last
);

    lsu_state_t              state, state_n;
    logic                    aw_done, aw_done_n;
    logic                    w_done, w_done_n;
    logic [ADDR_W-1:0]       addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [DATA_W/8-1:0]     wstrb_q;
    logic                    req_fire;

    // IDs, response LSBs, last flags and sub-doubleword address bits carry no
    // information for a single outstanding len=0 doubleword access.
    logic unused_bits;
    assign unused_bits = ^{req_addr[63:ADDR_W], req_addr[2:0], r_id, b_id,
                           r_last, r_resp[0], b_resp[0]};

    assign req_fire = req_valid && req_ready;

    // Constant AXI fields and registered payload.
    assign aw_id    = AXI_ID;
    assign ar_id    = AXI_ID;
    assign aw_addr  = addr_q;
    assign ar_addr  = addr_q;
    assign aw_len   = '0;
    assign ar_len   = '0;
    assign aw_size  = AXI_SIZE_8B;
    assign ar_size  = AXI_SIZE_8B;
    assign aw_burst = AXI_BURST_INCR;
    assign ar_burst = AXI_BURST_INCR;
    assign w_data   = wdata_q;
    assign w_strb   = wstrb_q;
    assign w_last   = 1'b1;

    // State register and write-channel completion flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
        end else begin
            state   <= state_n;
            aw_done <= aw_done_n;
            w_done  <= w_done_n;
        end
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        state_n   = state;
        aw_done_n = aw_done;
        w_done_n  = w_done;
        req_ready = 1'b0;
        ar_valid  = 1'b0;
        r_ready   = 1'b0;
        aw_valid  = 1'b0;
        w_valid   = 1'b0;
        b_ready   = 1'b0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = !reset;
                if (req_fire) begin
                    state_n   = req_wen ? WR_AW : RD_A;
                    aw_done_n = 1'b0;
                    w_done_n  = 1'b0;
                end
            end
            RD_A: begin
                ar_valid = 1'b1;
                if (ar_ready) state_n = RD_D;
            end
            RD_D: begin
                r_ready = 1'b1;
                if (r_valid) state_n = RESP;
            end
            WR_AW: begin
                // AW and W complete independently, in either order or together.
                aw_valid  = !aw_done;
                w_valid   = !w_done;
                aw_done_n = aw_done || aw_ready;
                w_done_n  = w_done || w_ready;
                if (aw_done_n && w_done_n) state_n = WR_B;
            end
            WR_B: begin
                b_ready = 1'b1;
                if (b_valid) state_n = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Request capture and response data/error capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            if (req_fire) begin
                addr_q  <= {req_addr[ADDR_W-1:3], 3'b000};
                wdata_q <= req_wdata;
                wstrb_q <= req_wstrb;
            end
            if (state == RD_D && r_valid) begin
                rsp_rdata <= r_data;
                rsp_err   <= r_resp[1];
            end
            if (state == WR_B && b_valid) begin
                rsp_rdata <= '0;
                rsp_err   <= b_resp[1];
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22041071_lsu_axi.sv
// Directed self-checking bench for ysyx_22041071_lsu_axi; the bench acts as
// both the MEM-stage requester and the AXI slave, cycle by cycle.
module tb_ysyx_22041071_lsu_axi;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, req_ready, req_wen = 1'b0;
    logic [63:0] req_addr = '0, req_wdata = '0;
    logic [7:0]  req_wstrb = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [63:0] rsp_rdata;
    logic        aw_valid, aw_ready = 1'b0;
    logic [3:0]  aw_id;
    logic [31:0] aw_addr;
    logic [7:0]  aw_len;
    logic [2:0]  aw_size;
    logic [1:0]  aw_burst;
    logic        w_valid, w_ready = 1'b0, w_last;
    logic [63:0] w_data;
    logic [7:0]  w_strb;
    logic        b_valid = 1'b0, b_ready;
    logic [3:0]  b_id = 4'h1;
    logic [1:0]  b_resp = '0;
    logic        ar_valid, ar_ready = 1'b0;
    logic [3:0]  ar_id;
    logic [31:0] ar_addr;
    logic [7:0]  ar_len;
    logic [2:0]  ar_size;
    logic [1:0]  ar_burst;
    logic        r_valid = 1'b0, r_ready, r_last = 1'b1;
    logic [3:0]  r_id = 4'h1;
    logic [63:0] r_data = '0;
    logic [1:0]  r_resp = '0;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    ysyx_22041071_lsu_axi #(
        .ADDR_W (32),
        .DATA_W (64),
        .ID_W   (4),
        .AXI_ID (4'h1)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
        .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb),
        .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
        .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
        .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data),
        .r_resp(r_resp), .r_last(r_last)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present a request at a negedge while the DUT is idle; returns after the
    // accepting posedge (at the following negedge).
    task automatic issue(input logic wen, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [7:0] wstrb);
        check("req_ready_idle", {63'd0, req_ready}, 64'd1);
        req_valid = 1'b1;
        req_wen   = wen;
        req_addr  = addr;
        req_wdata = wdata;
        req_wstrb = wstrb;
        @(negedge clk);
        check("req_ready_busy", {63'd0, req_ready}, 64'd0);
    endtask

    // Response phase: hold rsp_ready low for rsp_stall cycles, then consume.
    task automatic take_rsp(input logic [63:0] exp_data, input logic exp_err,
                            input int unsigned rsp_stall, input logic hold);
        check("rsp_valid", {63'd0, rsp_valid}, 64'd1);
        check("rsp_rdata", rsp_rdata, exp_data);
        check("rsp_err", {63'd0, rsp_err}, {63'd0, exp_err});
        for (int unsigned i = 0; i < rsp_stall; i++) begin
            @(negedge clk);
            check("bp_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            check("bp_rsp_rdata", rsp_rdata, exp_data);
            check("bp_req_ready", {63'd0, req_ready}, 64'd0);
            check("bp_no_ar", {63'd0, ar_valid}, 64'd0);
            check("bp_no_aw", {63'd0, aw_valid}, 64'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = hold;
        check("rsp_drop", {63'd0, rsp_valid}, 64'd0);
    endtask

    task automatic load_txn(input logic [63:0] addr, input logic [63:0] data,
                            input logic [1:0] resp, input int unsigned ar_stall,
                            input int unsigned rsp_stall, input logic hold);
        logic [31:0] exp_addr;
        exp_addr = {addr[31:3], 3'b000};
        issue(1'b0, addr, 64'd0, 8'd0);
        for (int unsigned i = 0; i <= ar_stall; i++) begin
            ar_ready = (i == ar_stall);
            check("ar_valid", {63'd0, ar_valid}, 64'd1);
            check("ar_addr", {32'd0, ar_addr}, {32'd0, exp_addr});
            check("aw_idle", {63'd0, aw_valid}, 64'd0);
            check("rsp_early", {63'd0, rsp_valid}, 64'd0);
            @(negedge clk);
        end
        ar_ready = 1'b0;
        check("ar_drop", {63'd0, ar_valid}, 64'd0);
        check("r_ready", {63'd0, r_ready}, 64'd1);
        r_valid = 1'b1;
        r_data  = data;
        r_resp  = resp;
        @(negedge clk);
        r_valid = 1'b0;
        r_data  = 64'hDEAD_DEAD_DEAD_DEAD;
        take_rsp(data, resp[1], rsp_stall, hold);
    endtask

    task automatic store_txn(input logic [63:0] addr, input logic [63:0] wdata,
                             input logic [7:0] wstrb, input logic [1:0] resp,
                             input int unsigned aw_stall, input int unsigned w_stall,
                             input logic hold);
        logic        aw_seen, w_seen;
        int unsigned cyc;
        logic [31:0] exp_addr;
        exp_addr = {addr[31:3], 3'b000};
        aw_seen  = 1'b0;
        w_seen   = 1'b0;
        cyc      = 0;
        issue(1'b1, addr, wdata, wstrb);
        while (!(aw_seen && w_seen) && cyc < 20) begin
            aw_ready = (cyc >= aw_stall);
            w_ready  = (cyc >= w_stall);
            check("aw_valid", {63'd0, aw_valid}, {63'd0, !aw_seen});
            check("w_valid", {63'd0, w_valid}, {63'd0, !w_seen});
            check("ar_idle", {63'd0, ar_valid}, 64'd0);
            if (!aw_seen) check("aw_addr", {32'd0, aw_addr}, {32'd0, exp_addr});
            if (!w_seen) begin
                check("w_data", w_data, wdata);
                check("w_strb", {56'd0, w_strb}, {56'd0, wstrb});
                check("w_last", {63'd0, w_last}, 64'd1);
            end
            @(negedge clk);
            aw_seen = aw_seen || aw_ready;
            w_seen  = w_seen || w_ready;
            cyc++;
        end
        aw_ready = 1'b0;
        w_ready  = 1'b0;
        check("wr_addr_phase_done", {63'd0, aw_seen && w_seen}, 64'd1);
        check("aw_drop", {63'd0, aw_valid}, 64'd0);
        check("w_drop", {63'd0, w_valid}, 64'd0);
        check("b_ready", {63'd0, b_ready}, 64'd1);
        b_valid = 1'b1;
        b_resp  = resp;
        @(negedge clk);
        b_valid = 1'b0;
        b_resp  = 2'b00;
        take_rsp(64'd0, resp[1], 0, hold);
    endtask

    initial begin
        // Reset values while reset is held.
        #1 reset = 1'b1;
        #2;
        check("rst_req_ready", {63'd0, req_ready}, 64'd0);
        check("rst_ar_valid", {63'd0, ar_valid}, 64'd0);
        check("rst_aw_valid", {63'd0, aw_valid}, 64'd0);
        check("rst_w_valid", {63'd0, w_valid}, 64'd0);
        check("rst_b_ready", {63'd0, b_ready}, 64'd0);
        check("rst_r_ready", {63'd0, r_ready}, 64'd0);
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_rsp_rdata", rsp_rdata, 64'd0);
        check("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("post_rst_req_ready", {63'd0, req_ready}, 64'd1);

        // Fixed AXI fields.
        check("ar_id", {60'd0, ar_id}, 64'h1);
        check("aw_id", {60'd0, aw_id}, 64'h1);
        check("ar_len", {56'd0, ar_len}, 64'd0);
        check("aw_len", {56'd0, aw_len}, 64'd0);
        check("ar_size", {61'd0, ar_size}, 64'd3);
        check("aw_size", {61'd0, aw_size}, 64'd3);
        check("ar_burst", {62'd0, ar_burst}, 64'd1);
        check("aw_burst", {62'd0, aw_burst}, 64'd1);

        // Immediate load, then 5 cycles of response backpressure.
        load_txn(64'h8000_0013, 64'h1122_3344_5566_7788, 2'b00, 0, 5, 1'b0);

        // Store with W accepted first and AW delayed 3 cycles.
        store_txn(64'h8000_0104, 64'h0000_0000_BEEF_0000, 8'h0C, 2'b00, 3, 0, 1'b0);

        // Error responses: SLVERR load, DECERR store (AW before W).
        load_txn(64'h8000_0208, 64'hCAFE_F00D_0BAD_BEEF, 2'b10, 1, 0, 1'b0);
        store_txn(64'h8000_0ABF, 64'hFFFF_0000_FFFF_0000, 8'hF0, 2'b11, 0, 2, 1'b0);

        // Reset while ar_valid is high and the slave stalls.
        issue(1'b0, 64'h8000_0300, 64'd0, 8'd0);
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_ar_valid", {63'd0, ar_valid}, 64'd1);
        #2 reset = 1'b1;
        #1;
        check("midrst_ar_valid", {63'd0, ar_valid}, 64'd0);
        check("midrst_req_ready", {63'd0, req_ready}, 64'd0);
        check("midrst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("midrst_rsp_rdata", rsp_rdata, 64'd0);
        check("midrst_r_ready", {63'd0, r_ready}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        load_txn(64'h8000_0318, 64'h0102_0304_0506_0708, 2'b00, 0, 0, 1'b0);

        // Back-to-back: two loads then a zero-strobe store, req_valid held.
        load_txn(64'h8000_1000, 64'hA5A5_A5A5_5A5A_5A5A, 2'b00, 0, 0, 1'b1);
        load_txn(64'h8000_1009, 64'h0F0F_0F0F_F0F0_F0F0, 2'b00, 0, 1, 1'b1);
        store_txn(64'h8000_1010, 64'h1234_5678_9ABC_DEF0, 8'h00, 2'b00, 0, 0, 1'b0);
        @(negedge clk);
        check("final_idle", {63'd0, req_ready}, 64'd1);
        check("final_no_ar", {63'd0, ar_valid}, 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ysyx_22041071_lsu_axi.md
Name: ysyx_22041071_lsu_axi

Overview:
- Data-side AXI4 master that turns one MEM-stage load or store into a single-beat AXI4 transaction.
- Sits between the MEM stage and the AXI crossbar.
- Loads: returns the raw aligned 64-bit doubleword. The MEM stage then does lane select and sign or zero extension.
- Stores: MEM pre-shifts the data and supplies byte strobes.
- One transaction outstanding at a time, with valid/ready handshakes on both sides.

Parameters:
- ADDR_W, 32: AXI address width.
- DATA_W, 64: data width. Fixed at 64; any other value is unsupported.
- ID_W, 4: AXI ID width.
- AXI_ID, 4'h1: constant ID driven on AW and AR.

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  MEM request valid
- req_ready  out  1  block can accept a request
- req_wen  in  1  1 = store, 0 = load
- req_addr  in  64  byte address (the ALU result)
- req_wdata  in  64  store data, already lane-shifted
- req_wstrb  in  8  byte strobes; bit i covers byte lane i
- rsp_valid  out  1  response valid
- rsp_ready  in  1  MEM consumes the response
- rsp_rdata  out  64  load doubleword; 0 for stores
- rsp_err  out  1  AXI returned SLVERR or DECERR
- aw_valid/aw_ready, aw_id[ID_W], aw_addr[ADDR_W], aw_len[8], aw_size[3], aw_burst[2]
- w_valid/w_ready, w_data[64], w_strb[8], w_last
- b_valid/b_ready, b_id[ID_W], b_resp[2]
- ar_valid/ar_ready, ar_id[ID_W], ar_addr[ADDR_W], ar_len[8], ar_size[3], ar_burst[2]
- r_valid/r_ready, r_id[ID_W], r_data[64], r_resp[2], r_last

Behaviour:
- Clocking and reset: one clock domain. Reset is asynchronous and active-high; all flops clear immediately when reset rises.
- Reset values:
  - state = IDLE.
  - All AXI valids = 0, b_ready = 0, r_ready = 0.
  - rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - req_ready = 1 once reset is deasserted.
- FSM states: IDLE, RD_A, RD_D, WR_AW, WR_B, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, register addr, wdata, wstrb and wen.
  - Next state is WR_AW if wen is 1, otherwise RD_A.
  - req_ready is 0 in every other state.
- Address formation: the AXI address is req_addr[ADDR_W-1:3] followed by 3'b000. Fixed fields: len = 0, size = 3'b011, burst = INCR (2'b01), w_last = 1.
- RD_A:
  - ar_valid = 1, held stable until ar_ready.
  - On handshake, go to RD_D.
- RD_D:
  - r_ready = 1.
  - On r_valid, capture r_data into rsp_rdata and set rsp_err = r_resp[1].
  - Go to RESP.
- WR_AW:
  - aw_valid and w_valid are asserted together.
  - Each is dropped independently once its own handshake occurs, tracked by aw_done and w_done flags.
  - When both are done, possibly in the same cycle, go to WR_B.
  - A W handshake before the AW handshake is legal.
- WR_B:
  - b_ready = 1.
  - On b_valid, set rsp_err = b_resp[1] and rsp_rdata = 0.
  - Go to RESP.
- RESP:
  - rsp_valid = 1; rsp_rdata and rsp_err are held stable.
  - On rsp_ready, go to IDLE. req_ready rises in the following cycle; there is no same-cycle turnaround.
- Latency: minimum 4 cycles from the request handshake to rsp_valid when the slave responds immediately:
  - cycle 1: request accepted
  - cycle 2: address handshake
  - cycle 3: data or B response captured
  - cycle 4: rsp_valid
- Stalls: any number of stall cycles on any AXI channel is tolerated, with payload held stable.
- Unchecked fields: r_id, b_id and r_last are not checked, since there is a single outstanding transaction with len = 0.
- Zero strobe: req_wstrb = 0 on a store still issues the write with w_strb = 0.
- Reset mid-transaction: the FSM returns to IDLE immediately. The partial transaction is abandoned; the interconnect is reset alongside.

Decomposition:
- Shared package or define file:
  - AXI constants: AXI_SIZE_8B = 3'b011, AXI_BURST_INCR = 2'b01, AXI_RESP_OKAY = 2'b00.
  - LSU state encoding.
- No sub-module. Write-channel tracking (the aw_done and w_done flags) stays inline.

Test Plan:
- Load, immediate slave: addr 0x8000_0013, r_data = 0x1122334455667788, resp OKAY. Expect ar_addr = 0x8000_0010, ar_size = 3, ar_len = 0, then rsp_valid with rsp_rdata = 0x1122334455667788 and rsp_err = 0, 4 cycles after the request handshake.
- Store, W before AW: req_wstrb = 8'h0C, wdata = 0x0000_0000_BEEF_0000. w_ready is held high, aw_ready is delayed 3 cycles. Expect w_valid to drop after its handshake, aw_valid held until cycle 3, w_strb = 0x0C, w_last = 1, then one rsp_valid with rsp_err = 0.
- Error response: a load returning r_resp = 2'b10 gives rsp_err = 1. A store with b_resp = 2'b11 gives rsp_err = 1 and rsp_rdata = 0.
- Backpressure: hold rsp_ready = 0 for 5 cycles. Expect rsp_valid and rsp_rdata stable, req_ready = 0 throughout, and no new AR or AW issued.
- Reset mid-op: assert reset while ar_valid = 1 and the slave is stalling. All outputs go to reset values in the same cycle without waiting for a clock edge. After release, a new load completes normally.
- Back-to-back: two loads, then a store, with no idle gaps on the requester. Each request is accepted only in IDLE, there is one response per request in order, and the data is correct.
